// File: rtl/costas_acq_ctrl.sv
// Acquisition/tracking sequencer for a Costas BPSK loop: sweeps the NCO start word,
// measures I/Q arm energy per window, declares lock and re-acquires on loss of lock.
module costas_acq_ctrl #(
    parameter logic [31:0] F_START    = 32'd286331153,
    parameter logic [31:0] F_STEP     = 32'd1048576,
    parameter int          N_STEPS    = 16,
    parameter int          SETTLE_CYC = 1024,
    parameter int          WIN_LOG2   = 8,
    parameter logic [31:0] AMP_MIN    = 32'd1024,
    parameter int          MISS_MAX   = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [15:0] i_data,
    input  logic [15:0] q_data,
    output logic [31:0] freq_word,
    output logic        lf_clear,
    output logic        gain_wide,
    output logic        locked,
    output logic [7:0]  sweep_idx,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_TRACK   = 3'd4
    } state_t;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [16:0] WIN_LAST    = 17'((1 << WIN_LOG2) - 1);
    localparam logic [3:0]  MISS_LAST   = 4'(MISS_MAX - 1);
    localparam logic [7:0]  IDX_LAST    = 8'(N_STEPS - 1);

    state_t        state_r;
    logic [31:0]   settle_cnt_r;
    logic [16:0]   win_cnt_r;
    logic [31:0]   acc_i_r;
    logic [31:0]   acc_q_r;
    logic [3:0]    miss_cnt_r;
    logic          eval_r;

    logic [31:0]   abs_i_s;
    logic [31:0]   abs_q_s;
    logic          win_end_s;
    logic          pass_s;

    // |x| with the single unrepresentable value -32768 clamped to 32767
    function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == 16'sh8000) begin
            r = 16'd32767;
        end else if (x < 16'sh0000) begin
            r = $unsigned(-x);
        end else begin
            r = $unsigned(x);
        end
        return r;
    endfunction

    // Lock metric: in-phase energy dominates quadrature by 2x and clears the floor
    function automatic logic window_pass(input logic [31:0] ai, input logic [31:0] aq);
        return ({1'b0, ai} >= {aq, 1'b0}) && (ai >= AMP_MIN);
    endfunction

    assign state = state_r;

    // Per-sample magnitudes, window-end strobe and the metric on the finished window
    always_comb begin
        abs_i_s   = {16'd0, abs_sat(i_data)};
        abs_q_s   = {16'd0, abs_sat(q_data)};
        win_end_s = sample_valid && (win_cnt_r == WIN_LAST);
        pass_s    = window_pass(acc_i_r, acc_q_r);
    end

    // Sequencer: state, sweep position, window accumulators and all registered outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !enable) begin
            state_r      <= ST_IDLE;
            freq_word    <= F_START;
            lf_clear     <= 1'b0;
            gain_wide    <= 1'b1;
            locked       <= 1'b0;
            sweep_idx    <= 8'd0;
            settle_cnt_r <= 32'd0;
            win_cnt_r    <= 17'd0;
            acc_i_r      <= 32'd0;
            acc_q_r      <= 32'd0;
            miss_cnt_r   <= 4'd0;
            eval_r       <= 1'b0;
        end else begin
            lf_clear <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r      <= ST_SETTLE;
                    lf_clear     <= 1'b1;
                    settle_cnt_r <= 32'd0;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r   <= ST_MEASURE;
                        acc_i_r   <= 32'd0;
                        acc_q_r   <= 32'd0;
                        win_cnt_r <= 17'd0;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 32'd1;
                    end
                end
                ST_MEASURE: begin
                    if (sample_valid) begin
                        acc_i_r   <= acc_i_r + abs_i_s;
                        acc_q_r   <= acc_q_r + abs_q_s;
                        win_cnt_r <= win_cnt_r + 17'd1;
                        if (win_end_s) begin
                            state_r <= ST_DECIDE;
                        end
                    end
                end
                ST_DECIDE: begin
                    if (pass_s) begin
                        state_r    <= ST_TRACK;
                        locked     <= 1'b1;
                        gain_wide  <= 1'b0;
                        acc_i_r    <= 32'd0;
                        acc_q_r    <= 32'd0;
                        win_cnt_r  <= 17'd0;
                        miss_cnt_r <= 4'd0;
                        eval_r     <= 1'b0;
                    end else begin
                        if (sweep_idx == IDX_LAST) begin
                            sweep_idx <= 8'd0;
                            freq_word <= F_START;
                        end else begin
                            sweep_idx <= sweep_idx + 8'd1;
                            freq_word <= freq_word + F_STEP;
                        end
                        state_r      <= ST_SETTLE;
                        lf_clear     <= 1'b1;
                        settle_cnt_r <= 32'd0;
                    end
                end
                ST_TRACK: begin
                    if (eval_r) begin
                        // Evaluation cycle also opens the next window so windows stay back-to-back
                        eval_r    <= 1'b0;
                        acc_i_r   <= sample_valid ? abs_i_s : 32'd0;
                        acc_q_r   <= sample_valid ? abs_q_s : 32'd0;
                        win_cnt_r <= sample_valid ? 17'd1 : 17'd0;
                        if (pass_s) begin
                            miss_cnt_r <= 4'd0;
                        end else if (miss_cnt_r == MISS_LAST) begin
                            miss_cnt_r   <= 4'd0;
                            locked       <= 1'b0;
                            gain_wide    <= 1'b1;
                            state_r      <= ST_SETTLE;
                            lf_clear     <= 1'b1;
                            settle_cnt_r <= 32'd0;
                        end else begin
                            miss_cnt_r <= miss_cnt_r + 4'd1;
                        end
                    end else if (sample_valid) begin
                        acc_i_r   <= acc_i_r + abs_i_s;
                        acc_q_r   <= acc_q_r + abs_q_s;
                        win_cnt_r <= win_cnt_r + 17'd1;
                        if (win_end_s) begin
                            eval_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Self-checking bench for costas_acq_ctrl: a scoreboard queue of expected lf_clear events
// (frequency word and sweep index) plus direct checks of lock timing and reset behaviour.
module tb_costas_acq_ctrl;

    localparam logic [31:0] F_START = 32'd286331153;
    localparam logic [31:0] F_STEP  = 32'd1048576;

    logic        clk = 1'b0;
    logic        rst_n, en, en2, valid;
    logic [15:0] i_d, q_d, i2, q2;
    logic [31:0] freq_word, sat_freq;
    logic        lf_clear, gain_wide, locked, sat_clr, sat_gain, sat_locked;
    logic [7:0]  sweep_idx, sat_idx;
    logic [2:0]  state, sat_state;

    always #5 clk = ~clk;

    costas_acq_ctrl u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .enable(en), .sample_valid(valid),
        .i_data(i_d), .q_data(q_d), .freq_word(freq_word), .lf_clear(lf_clear),
        .gain_wide(gain_wide), .locked(locked), .sweep_idx(sweep_idx), .state(state)
    );

    costas_acq_ctrl #(.WIN_LOG2(1), .AMP_MIN(32'd65534), .SETTLE_CYC(4)) u_sat (
        .sys_clk(clk), .sys_rst_n(rst_n), .enable(en2), .sample_valid(valid),
        .i_data(i2), .q_data(q2), .freq_word(sat_freq), .lf_clear(sat_clr),
        .gain_wide(sat_gain), .locked(sat_locked), .sweep_idx(sat_idx), .state(sat_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] freq;
        logic [7:0]  idx;
    } clr_exp_t;

    clr_exp_t clr_q[$];
    clr_exp_t mon_e;
    logic     prev_clr = 1'b0;

    // Scoreboard: every lf_clear pulse must be expected and carry the expected sweep point
    always @(negedge clk) begin
        if (lf_clear) begin
            check_eq("clr_width", prev_clr, 1'b0);
            if (clr_q.size() == 0) begin
                check_eq("clr_unexpected", lf_clear, 1'b0);
            end else begin
                mon_e = clr_q.pop_front();
                check_eq("clr_freq", freq_word, mon_e.freq);
                check_eq("clr_idx", sweep_idx, mon_e.idx);
                check_eq("clr_gain", gain_wide, 1'b1);
            end
        end
        prev_clr <= lf_clear;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_state"},  state, 3'd0);
        check_eq({tag, "_freq"},   freq_word, F_START);
        check_eq({tag, "_clr"},    lf_clear, 1'b0);
        check_eq({tag, "_gain"},   gain_wide, 1'b1);
        check_eq({tag, "_locked"}, locked, 1'b0);
        check_eq({tag, "_idx"},    sweep_idx, 8'd0);
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = 0;
        while (!locked && n < bound) begin
            tick(1);
            n++;
        end
    endtask

    task automatic run_sweep(input int bound, output logic saw_lock);
        int n;
        n = 0;
        saw_lock = 1'b0;
        while (clr_q.size() > 0 && n < bound) begin
            tick(1);
            if (locked) saw_lock = 1'b1;
            n++;
        end
    endtask

    initial begin
        int   n;
        logic saw;
        rst_n = 1'b0; en = 1'b0; en2 = 1'b0; valid = 1'b0;
        i_d = 16'd0; q_d = 16'd0; i2 = 16'd0; q2 = 16'd0;
        tick(3);
        check_idle("reset");
        rst_n = 1'b1;
        tick(2);
        check_eq("idle_hold_state", state, 3'd0);

        // Acquisition on the first sweep point with a strong in-phase arm
        i_d = 16'd1000; q_d = 16'd100; valid = 1'b1;
        clr_q.push_back('{freq: F_START, idx: 8'd0});
        en = 1'b1;
        tick(1);
        check_eq("t1_settle", state, 3'd1);
        wait_locked(1400, n);
        check_eq("t1_lock_cycles", n, 1281);
        check_eq("t1_gain", gain_wide, 1'b0);
        check_eq("t1_freq", freq_word, F_START);
        check_eq("t1_state", state, 3'd4);

        // Loss of lock: three failing track windows, re-acquire at the same point
        i_d = 16'd0; q_d = 16'd1000;
        clr_q.push_back('{freq: F_START, idx: 8'd0});
        n = 0;
        while (locked && n < 2000) begin
            tick(1);
            n++;
        end
        check_eq("t4_drop_cycles", n, 769);
        check_eq("t4_gain", gain_wide, 1'b1);
        check_eq("t4_freq", freq_word, F_START);
        check_eq("t4_state", state, 3'd1);

        // Disable in the middle of a measurement window
        tick(1030);
        check_eq("t6_measure", state, 3'd2);
        en = 1'b0;
        tick(1);
        check_idle("t6_disable");

        // Full sweep with quadrature dominant: 16 steps then wrap to the start word
        i_d = 16'd100; q_d = 16'd1000;
        for (int k = 0; k < 16; k++) begin
            clr_q.push_back('{freq: F_START + 32'(k) * F_STEP, idx: 8'(k)});
        end
        clr_q.push_back('{freq: F_START, idx: 8'd0});
        en = 1'b1;
        run_sweep(17 * 1281 + 50, saw);
        check_eq("t2_sweep_done", clr_q.size(), 0);
        check_eq("t2_no_lock", saw, 1'b0);
        check_eq("t2_wrap_freq", freq_word, F_START);
        en = 1'b0;
        tick(1);

        // Tiny amplitude: Q=0 but energy below the floor, sweep keeps going
        i_d = 16'd2; q_d = 16'd0;
        for (int k = 0; k < 4; k++) begin
            clr_q.push_back('{freq: F_START + 32'(k) * F_STEP, idx: 8'(k)});
        end
        en = 1'b1;
        run_sweep(4 * 1281 + 50, saw);
        check_eq("t3_sweep_done", clr_q.size(), 0);
        check_eq("t3_no_lock", saw, 1'b0);
        check_eq("t3_idx", sweep_idx, 8'd3);
        en = 1'b0;
        tick(1);
        check_idle("t3_disable");

        // Synchronous reset while tracking
        i_d = 16'd1000; q_d = 16'd100;
        clr_q.push_back('{freq: F_START, idx: 8'd0});
        en = 1'b1;
        wait_locked(1400, n);
        check_eq("t6_locked", locked, 1'b1);
        tick(100);
        check_eq("t6_track", state, 3'd4);
        rst_n = 1'b0;
        tick(1);
        check_idle("t6_reset");
        en = 1'b0;
        rst_n = 1'b1;
        tick(1);
        check_eq("t6_after_reset", state, 3'd0);

        // Saturation of |-32768|: Q=16384 sits right between 32767 and 32768 per sample
        i2 = 16'h8000; q2 = 16'd16384;
        en2 = 1'b1;
        tick(1);
        tick(35);
        check_eq("t5_idx", sat_idx, 8'd5);
        check_eq("t5_no_lock", sat_locked, 1'b0);
        q2 = 16'd0;
        tick(7);
        check_eq("t5_locked", sat_locked, 1'b1);
        check_eq("t5_freq", sat_freq, F_START + 32'd5 * F_STEP);
        check_eq("t5_gain", sat_gain, 1'b0);
        en2 = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
